// File: rtl/wb_irq_timer_pkg.sv
// Shared register map, CTRL/STATUS bit positions and byte-lane helper for wb_irq_timer.
package wb_irq_timer_pkg;

    // Word index, taken from wb_adr_i[4:2]
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_LOAD   = 3'd1;
    localparam logic [2:0] REG_COUNT  = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;

    // CTRL fields
    localparam int unsigned CTRL_EN        = 0;
    localparam int unsigned CTRL_PERIODIC  = 1;
    localparam int unsigned CTRL_IE        = 2;
    localparam int unsigned CTRL_PRESC_LSB = 8;

    // STATUS fields
    localparam int unsigned STATUS_PEND = 0;

    // Replace only the byte lanes enabled in sel
    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{sel[i]}};
        end
        return (old_v & ~m) | (new_v & m);
    endfunction

endpackage

// File: rtl/wb_irq_timer_if.sv
// Wishbone B3 classic slave bus bundle for wb_irq_timer.
interface wb_irq_timer_if;
    logic [4:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/wb_irq_timer_cnt.sv
// Prescaler and down-counter; flags expiry when a tick lands on COUNT==0.
module wb_irq_timer_cnt #(
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  periodic_i,
    input  logic [PRESCALE_W-1:0] presc_i,
    input  logic [31:0]           load_i,
    input  logic                  ctrl_wr_i,
    input  logic                  cnt_wr_i,
    input  logic [31:0]           cnt_wdata_i,
    output logic [31:0]           count_o,
    output logic                  expire_o
);

    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic                  tick_q, tick_d;
    logic [31:0]           count_q, count_d;
    logic                  tick;

    // Tick is registered; gating with EN drops a tick left over from the cycle EN was cleared
    assign tick     = tick_q & en_i;
    assign expire_o = tick & (count_q == '0);
    assign count_o  = count_q;

    // Prescaler: count 0..PRESC, tick on the wrap; cleared while disabled or on CTRL write
    always_comb begin
        pcnt_d = pcnt_q;
        tick_d = 1'b0;
        if (!en_i || ctrl_wr_i) begin
            pcnt_d = '0;
        end else if (pcnt_q == presc_i) begin
            pcnt_d = '0;
            tick_d = 1'b1;
        end else begin
            pcnt_d = pcnt_q + PRESCALE_W'(1);
        end
    end

    // Counter: bus write wins over decrement or reload
    always_comb begin
        count_d = count_q;
        if (cnt_wr_i) begin
            count_d = cnt_wdata_i;
        end else if (tick) begin
            if (count_q != '0)  count_d = count_q - 32'd1;
            else if (periodic_i) count_d = load_i;
            else                 count_d = '0;
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pcnt_q  <= '0;
            tick_q  <= 1'b0;
            count_q <= '0;
        end else begin
            pcnt_q  <= pcnt_d;
            tick_q  <= tick_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_irq_timer.sv
// Wishbone-mapped interval timer with level interrupt.
module wb_irq_timer
    import wb_irq_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 8,
    parameter logic [31:0] LOAD_RESET = 32'h0
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    wb_irq_timer_if.slave  wb,
    output logic           irq_o
);

    logic                  en_q, en_d, per_q, per_d, ie_q, ie_d, pend_q, pend_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [31:0]           load_q, load_d;
    logic                  ack_q, ack_d, err_q, err_d;
    logic [31:0]           dat_q, dat_d;

    logic        req, bad, wr_ok, ctrl_wr, load_wr, cnt_wr, stat_wr;
    logic [2:0]  word;
    logic [31:0] count, rdata, ctrl_img, ctrl_base, ctrl_new;
    logic        expire, en_hw;
    logic        unused_ok;

    assign req     = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
    assign bad     = wb.wb_adr_i[4];
    assign word    = wb.wb_adr_i[4:2];
    assign wr_ok   = req & wb.wb_we_i & ~bad;
    assign ctrl_wr = wr_ok & (word == REG_CTRL);
    assign load_wr = wr_ok & (word == REG_LOAD);
    assign cnt_wr  = wr_ok & (word == REG_COUNT);
    assign stat_wr = wr_ok & (word == REG_STATUS);

    // Hardware clear of EN on one-shot expiry; a CTRL write merges over this value
    assign en_hw = en_q & ~(expire & ~per_q);

    // CTRL image for reads (current) and as write base (after hardware clear)
    always_comb begin
        ctrl_img = '0;
        ctrl_img[CTRL_EN]       = en_q;
        ctrl_img[CTRL_PERIODIC] = per_q;
        ctrl_img[CTRL_IE]       = ie_q;
        ctrl_img[CTRL_PRESC_LSB +: PRESCALE_W] = presc_q;
        ctrl_base = ctrl_img;
        ctrl_base[CTRL_EN]      = en_hw;
    end

    assign ctrl_new = lane_merge(ctrl_base, wb.wb_dat_i, wb.wb_sel_i);

    wb_irq_timer_cnt #(.PRESCALE_W(PRESCALE_W)) u_cnt (
        .clk_i       (wb_clk_i),
        .rst_i       (wb_rst_i),
        .en_i        (en_q),
        .periodic_i  (per_q),
        .presc_i     (presc_q),
        .load_i      (load_q),
        .ctrl_wr_i   (ctrl_wr),
        .cnt_wr_i    (cnt_wr),
        .cnt_wdata_i (lane_merge(count, wb.wb_dat_i, wb.wb_sel_i)),
        .count_o     (count),
        .expire_o    (expire)
    );

    // Register next-state: bus writes, W1C of PEND, expiry sets PEND last so it wins
    always_comb begin
        en_d    = en_hw;
        per_d   = per_q;
        ie_d    = ie_q;
        presc_d = presc_q;
        load_d  = load_q;
        pend_d  = pend_q;
        if (ctrl_wr) begin
            en_d    = ctrl_new[CTRL_EN];
            per_d   = ctrl_new[CTRL_PERIODIC];
            ie_d    = ctrl_new[CTRL_IE];
            presc_d = ctrl_new[CTRL_PRESC_LSB +: PRESCALE_W];
        end
        if (load_wr) load_d = lane_merge(load_q, wb.wb_dat_i, wb.wb_sel_i);
        if (stat_wr && wb.wb_sel_i[0] && wb.wb_dat_i[STATUS_PEND]) pend_d = 1'b0;
        if (expire) pend_d = 1'b1;
    end

    // Read mux, sampled at request time
    always_comb begin
        rdata = '0;
        case (word)
            REG_CTRL:   rdata = ctrl_img;
            REG_LOAD:   rdata = load_q;
            REG_COUNT:  rdata = count;
            REG_STATUS: rdata[STATUS_PEND] = pend_q;
            default:    rdata = '0;
        endcase
    end

    // Single-cycle termination; error window 0x10-0x1C reads 0
    always_comb begin
        ack_d = req & ~bad;
        err_d = req & bad;
        dat_d = (req && !bad && !wb.wb_we_i) ? rdata : '0;
    end

    // State registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            en_q    <= 1'b0;
            per_q   <= 1'b0;
            ie_q    <= 1'b0;
            presc_q <= '0;
            load_q  <= LOAD_RESET;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            en_q    <= en_d;
            per_q   <= per_d;
            ie_q    <= ie_d;
            presc_q <= presc_d;
            load_q  <= load_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_rty_o = 1'b0;
    assign irq_o       = pend_q & ie_q;

    assign unused_ok = ^{wb.wb_adr_i[1:0], ctrl_new};

endmodule

// File: tb/tb_wb_irq_timer.sv
// Directed self-checking bench for wb_irq_timer.
module tb_wb_irq_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    wb_irq_timer_if bus ();

    wb_irq_timer #(.PRESCALE_W(8), .LOAD_RESET(32'h0)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (bus),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One classic transfer; request sampled at the next rising edge, bounded wait for termination
    task automatic wb_xfer(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdata,
                           output logic ack, output logic err);
        bit done;
        done  = 1'b0;
        rdata = '0;
        ack   = 1'b0;
        err   = 1'b0;
        @(negedge clk);
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        bus.wb_we_i  = we;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            @(posedge clk);
            #1;
            if (bus.wb_ack_o || bus.wb_err_o) begin
                ack   = bus.wb_ack_o;
                err   = bus.wb_err_o;
                rdata = bus.wb_dat_o;
                done  = 1'b1;
            end
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        check_eq("bus_term", {31'b0, ack | err}, 32'd1);
    endtask

    task automatic wb_wr(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] d;
        logic a, e;
        wb_xfer(1'b1, adr, dat, sel, d, a, e);
    endtask

    task automatic wb_rd(input logic [4:0] adr, output logic [31:0] d);
        logic a, e;
        wb_xfer(1'b0, adr, 32'h0, 4'hF, d, a, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic a, e;

        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        bus.wb_sel_i = '0;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;

        // Reset values
        #2;
        check_eq("rst_irq", {31'b0, irq}, 32'd0);
        check_eq("rst_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        check_eq("rst_err", {31'b0, bus.wb_err_o}, 32'd0);
        check_eq("rst_dat", bus.wb_dat_o, 32'd0);
        check_eq("rst_rty", {31'b0, bus.wb_rty_o}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wb_rd(5'h00, d); check_eq("rst_ctrl", d, 32'h0);
        wb_rd(5'h04, d); check_eq("rst_load", d, 32'h0);
        wb_rd(5'h08, d); check_eq("rst_count", d, 32'h0);
        wb_rd(5'h0C, d); check_eq("rst_status", d, 32'h0);

        // Byte lanes
        wb_wr(5'h04, 32'hFFFF_FFFF, 4'hF);
        wb_wr(5'h04, 32'h0000_0000, 4'b0010);
        wb_rd(5'h04, d); check_eq("lane_load", d, 32'hFFFF_00FF);

        // Error window
        wb_xfer(1'b0, 5'h14, 32'h0, 4'hF, d, a, e);
        check_eq("err_rd_err", {31'b0, e}, 32'd1);
        check_eq("err_rd_ack", {31'b0, a}, 32'd0);
        check_eq("err_rd_dat", d, 32'h0);
        wb_xfer(1'b1, 5'h10, 32'hFFFF_FFFF, 4'hF, d, a, e);
        check_eq("err_wr_err", {31'b0, e}, 32'd1);
        wb_xfer(1'b1, 5'h18, 32'h0000_1234, 4'hF, d, a, e);
        wb_rd(5'h00, d); check_eq("err_ctrl", d, 32'h0);
        wb_rd(5'h08, d); check_eq("err_count", d, 32'h0);
        wb_rd(5'h04, d); check_eq("err_load", d, 32'hFFFF_00FF);
        check_eq("rty_0", {31'b0, bus.wb_rty_o}, 32'd0);

        // One-shot: expiry lands 5 edges after the CTRL write edge
        wb_wr(5'h04, 32'd3, 4'hF);
        wb_wr(5'h08, 32'd3, 4'hF);
        wb_wr(5'h00, 32'h0000_0005, 4'hF);
        cycles(4);
        check_eq("os_irq_early", {31'b0, irq}, 32'd0);
        cycles(1);
        check_eq("os_irq", {31'b0, irq}, 32'd1);
        wb_rd(5'h0C, d); check_eq("os_pend", d, 32'h1);
        wb_rd(5'h00, d); check_eq("os_ctrl", d, 32'h4);
        wb_rd(5'h08, d); check_eq("os_count", d, 32'h0);
        wb_wr(5'h0C, 32'h1, 4'hF);
        check_eq("os_w1c", {31'b0, irq}, 32'd0);

        // Periodic, PRESC=2, LOAD=1: expiries at E4, E10, E16 after the CTRL write edge E0
        wb_wr(5'h08, 32'd0, 4'hF);
        wb_wr(5'h04, 32'd1, 4'hF);
        wb_wr(5'h00, 32'h0000_0207, 4'hF);
        cycles(3);
        check_eq("per_e3", {31'b0, irq}, 32'd0);
        cycles(1);
        check_eq("per_e4", {31'b0, irq}, 32'd1);
        wb_wr(5'h0C, 32'h1, 4'hF);
        check_eq("per_w1c1", {31'b0, irq}, 32'd0);
        cycles(4);
        check_eq("per_e9", {31'b0, irq}, 32'd0);
        cycles(1);
        check_eq("per_e10", {31'b0, irq}, 32'd1);
        wb_wr(5'h0C, 32'h1, 4'hF);
        check_eq("per_w1c2", {31'b0, irq}, 32'd0);
        cycles(4);
        wb_wr(5'h0C, 32'h1, 4'hF);
        check_eq("w1c_vs_expiry", {31'b0, irq}, 32'd1);
        cycles(2);
        wb_wr(5'h08, 32'h10, 4'hF);
        wb_wr(5'h00, 32'h0, 4'hF);
        wb_rd(5'h08, d); check_eq("cnt_wr_vs_tick", d, 32'h10);
        wb_wr(5'h0C, 32'h1, 4'hF);
        wb_rd(5'h0C, d); check_eq("per_clear", d, 32'h0);

        // Async reset mid-transfer
        wb_wr(5'h08, 32'd0, 4'hF);
        wb_wr(5'h00, 32'h0000_0005, 4'hF);
        cycles(3);
        check_eq("ar_irq_pre", {31'b0, irq}, 32'd1);
        wb_wr(5'h08, 32'h20, 4'hF);
        @(negedge clk);
        bus.wb_adr_i = 5'h08;
        bus.wb_dat_i = 32'h77;
        bus.wb_sel_i = 4'hF;
        bus.wb_we_i  = 1'b1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_irq", {31'b0, irq}, 32'd0);
        check_eq("ar_ack_now", {31'b0, bus.wb_ack_o}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("ar_ack_edge", {31'b0, bus.wb_ack_o}, 32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wb_rd(5'h08, d); check_eq("ar_count", d, 32'h0);
        wb_rd(5'h00, d); check_eq("ar_ctrl", d, 32'h0);
        check_eq("rty_1", {31'b0, bus.wb_rty_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
